// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the jtdsp16 data-RAM path: default sizes and
// the compound-access sequencer state encoding.
package jtdsp16_pkg;

    localparam int unsigned RamAw = 11;
    localparam int unsigned RamDw = 16;

    typedef enum logic {
        StIdle  = 1'b0,
        StCmpWr = 1'b1
    } ram_state_e;

endpackage

// File: rtl/jtdsp16_ram_array.sv
// Plain 2^AW x DW storage: one synchronous write port, one synchronous
// read port, no reset so it maps onto block RAM.
module jtdsp16_ram_array
    import jtdsp16_pkg::*;
#(
    parameter int unsigned AW = RamAw,
    parameter int unsigned DW = RamDw
) (
    input  logic          clk,
    input  logic          cen,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Write and registered read; a same-address collision returns the old
    // word, which the parent always overrides through its bypass path.
    always_ff @(posedge clk) begin
        if (cen) begin
            if (we) mem[waddr] <= wdata;
            if (re) rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/jtdsp16_ram.sv
// Data RAM stage after the YAAU: synchronous read with write-buffer bypass,
// a posted one-entry write buffer and a read-then-write compound sequencer.
module jtdsp16_ram
    import jtdsp16_pkg::*;
#(
    parameter int unsigned AW = RamAw,
    parameter int unsigned DW = RamDw
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic [AW-1:0] addr,
    input  logic          rd_req,
    input  logic          wr_req,
    input  logic          cmp_req,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          busy,
    output logic          err
);

    ram_state_e state_q, state_d;

    logic          wb_vld_q, wb_vld_d;
    logic [AW-1:0] wb_addr_q, wb_addr_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic [AW-1:0] cmp_addr_q;
    logic [DW-1:0] cmp_data_q;

    logic          rd_valid_q;
    logic          rd_byp_q;
    logic [DW-1:0] byp_data_q;
    logic          err_q;
    logic [DW-1:0] arr_rdata;

    logic [1:0] req_cnt;
    logic       req_any, req_multi, idle;
    logic       rd_go, wr_go, cmp_go, err_set, byp_hit;

    // Request decode: with conflicting requests only the read survives.
    always_comb begin
        req_cnt   = {1'b0, rd_req} + {1'b0, wr_req} + {1'b0, cmp_req};
        req_any   = (req_cnt != 2'd0);
        req_multi = (req_cnt > 2'd1);
        idle      = (state_q == StIdle);
        rd_go     = idle & (rd_req | cmp_req);
        wr_go     = idle & wr_req & ~req_multi;
        cmp_go    = idle & cmp_req & ~req_multi;
        err_set   = req_multi | (~idle & req_any);
        byp_hit   = wb_vld_q && (wb_addr_q == addr);
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else if (cen) begin
            state_q <= state_d;
        end
    end

    // Sequencer next state: the write phase always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (cmp_go) state_d = StCmpWr;
            StCmpWr: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Sequencer outputs.
    always_comb begin
        busy = (state_q == StCmpWr);
    end

    // Write buffer next state: the occupant always commits, so the buffer
    // is only valid again if something reloads it on this edge.
    always_comb begin
        wb_vld_d  = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (state_q == StCmpWr) begin
            wb_vld_d  = 1'b1;
            wb_addr_d = cmp_addr_q;
            wb_data_d = cmp_data_q;
        end else if (wr_go) begin
            wb_vld_d  = 1'b1;
            wb_addr_d = addr;
            wb_data_d = wr_data;
        end
    end

    // Write buffer and compound-write holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_vld_q   <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            cmp_addr_q <= '0;
            cmp_data_q <= '0;
        end else if (cen) begin
            wb_vld_q  <= wb_vld_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            if (cmp_go) begin
                cmp_addr_q <= addr;
                cmp_data_q <= wr_data;
            end
        end
    end

    // Read result tracking; resetting onto the bypass path with zero data
    // makes rd_data read 0 without resetting the array output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_byp_q   <= 1'b1;
            byp_data_q <= '0;
        end else if (cen) begin
            rd_valid_q <= rd_go;
            if (rd_go) begin
                rd_byp_q   <= byp_hit;
                byp_data_q <= wb_data_q;
            end
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (cen && err_set) begin
            err_q <= 1'b1;
        end
    end

    jtdsp16_ram_array #(
        .AW(AW),
        .DW(DW)
    ) u_array (
        .clk   (clk),
        .cen   (cen),
        .we    (wb_vld_q),
        .waddr (wb_addr_q),
        .wdata (wb_data_q),
        .re    (rd_go),
        .raddr (addr),
        .rdata (arr_rdata)
    );

    // Output selection.
    always_comb begin
        rd_data  = rd_byp_q ? byp_data_q : arr_rdata;
        rd_valid = rd_valid_q;
        err      = err_q;
    end

endmodule

// File: tb/tb_jtdsp16_ram.sv
// Scoreboarded bench for jtdsp16_ram: a flat memory model predicts each read
// at issue time, a monitor compares whenever rd_valid is seen on a cen edge.
module tb_jtdsp16_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic [10:0] addr;
    logic        rd_req, wr_req, cmp_req;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        rd_valid, busy, err;

    jtdsp16_ram dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .addr     (addr),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .cmp_req  (cmp_req),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: memory as seen by software, plus busy/err flags.
    logic [15:0] mdl_mem [2048];
    bit          mdl_busy = 0;
    bit          mdl_err  = 0;
    logic [15:0] exp_q [$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural effect of one accepted cen cycle.
    task automatic model(input bit r, input bit w, input bit m,
                         input logic [10:0] a, input logic [15:0] d);
        int n;
        n = int'(r) + int'(w) + int'(m);
        if (mdl_busy) begin
            if (n != 0) mdl_err = 1;
            mdl_busy = 0;
        end else if (n > 1) begin
            mdl_err = 1;
            if (r || m) exp_q.push_back(mdl_mem[a]);
        end else if (r) begin
            exp_q.push_back(mdl_mem[a]);
        end else if (w) begin
            mdl_mem[a] = d;
        end else if (m) begin
            exp_q.push_back(mdl_mem[a]);
            mdl_mem[a] = d;
            mdl_busy = 1;
        end
    endtask

    // Drive one cycle from a negedge, then check flags at the next negedge.
    task automatic step(input bit c, input bit r, input bit w, input bit m,
                        input logic [10:0] a, input logic [15:0] d);
        cen = c; rd_req = r; wr_req = w; cmp_req = m; addr = a; wr_data = d;
        if (c) model(r, w, m, a, d);
        @(negedge clk);
        check("busy", {15'd0, busy}, {15'd0, mdl_busy});
        check("err", {15'd0, err}, {15'd0, mdl_err});
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 11'h0, 16'h0);
    endtask

    // Monitor: on every enabled edge, a rd_valid must match the oldest prediction.
    logic        mon_cen;
    logic [15:0] mon_exp;
    always @(posedge clk) begin
        mon_cen = cen & rst_n;
        #1;
        if (mon_cen && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL rd_unexpected: got %h with no read pending at %0t", rd_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_data", rd_data, mon_exp);
            end
        end
    end

    initial begin
        logic [15:0] held;
        logic [15:0] old;
        bit r, w, m;
        int op;

        rst_n = 1'b0; cen = 1'b0; addr = '0; rd_req = 0; wr_req = 0; cmp_req = 0;
        wr_data = '0;
        #1;
        check("reset_rd_data", rd_data, 16'h0);
        check("reset_rd_valid", {15'd0, rd_valid}, 16'h0);
        check("reset_busy", {15'd0, busy}, 16'h0);
        check("reset_err", {15'd0, err}, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Write then immediate read: served from the write buffer.
        step(1, 0, 1, 0, 11'h005, 16'h1234);
        step(1, 1, 0, 0, 11'h005, 16'h0);
        idle();
        check("rd_valid_one_pulse", {15'd0, rd_valid}, 16'h0);

        // Read from the array after the buffer has drained.
        step(1, 0, 1, 0, 11'h7FF, 16'hAAAA);
        step(1, 0, 1, 0, 11'h000, 16'h0000);
        idle();
        idle();
        step(1, 1, 0, 0, 11'h7FF, 16'h0);
        step(1, 1, 0, 0, 11'h000, 16'h0);

        // Compound access returns the old word and lands the new one.
        step(1, 0, 1, 0, 11'h010, 16'h1111);
        idle();
        step(1, 0, 0, 1, 11'h010, 16'h2222);
        idle();
        step(1, 1, 0, 0, 11'h010, 16'h0);

        // cen stall around a read: result frozen, requests ignored.
        step(1, 1, 0, 0, 11'h7FF, 16'h0);
        held = rd_data;
        step(0, 1, 0, 0, 11'h005, 16'h0);
        check("stall_rd_valid", {15'd0, rd_valid}, 16'h1);
        check("stall_rd_data", rd_data, 16'hAAAA);
        step(0, 0, 1, 0, 11'h005, 16'hDEAD);
        check("stall2_rd_valid", {15'd0, rd_valid}, 16'h1);
        check("stall2_rd_data", rd_data, held);
        idle();
        check("post_stall_rd_valid", {15'd0, rd_valid}, 16'h0);
        check("post_stall_hold", rd_data, 16'hAAAA);
        step(1, 1, 0, 0, 11'h005, 16'h0);

        // Write during the compound write phase: flagged and dropped.
        step(1, 0, 0, 1, 11'h010, 16'h3333);
        step(1, 0, 1, 0, 11'h011, 16'hBEEF);
        step(1, 1, 0, 0, 11'h010, 16'h0);
        idle();

        // Randomized traffic over a preloaded address pool.
        for (int i = 0; i < 32; i++) step(1, 0, 1, 0, 11'h100 + 11'(i), 16'($urandom));
        idle();
        for (int i = 0; i < 500; i++) begin
            op = $urandom_range(0, 9);
            r = (op <= 2); w = (op >= 3 && op <= 5); m = (op == 6 || op == 7);
            if (op == 9) begin
                r = 1'($urandom); w = 1'($urandom); m = 1'($urandom);
                if (!r && !w) begin r = 1; w = 1; end
            end
            step($urandom_range(0, 3) != 0, r, w, m,
                 11'h100 + 11'($urandom_range(0, 31)), 16'($urandom));
        end
        idle();
        idle();

        // Asynchronous reset during the compound write phase loses the write.
        step(1, 0, 1, 0, 11'h020, 16'h5555);
        idle();
        old = mdl_mem[11'h020];
        step(1, 0, 0, 1, 11'h020, 16'h9999);
        rst_n = 1'b0;
        #1;
        check("rst_busy", {15'd0, busy}, 16'h0);
        check("rst_rd_data", rd_data, 16'h0);
        check("rst_rd_valid", {15'd0, rd_valid}, 16'h0);
        check("rst_err", {15'd0, err}, 16'h0);
        mdl_mem[11'h020] = old;
        mdl_busy = 0;
        mdl_err  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        step(1, 1, 0, 0, 11'h020, 16'h0);
        idle();
        idle();

        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL reads_outstanding: got %0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
